rf_write_arbiter: RTL
=====================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter D, default 32: write-data width in bits, equal to the register file data width.
REQ-002 Parameter N, default 3: number of write requesters, N >= 2.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port req_valid, input, N bits: bit i high means requester i offers a write.
REQ-006 Port req_addr, input, 5*N bits: requester i destination register in bits [5i+4:5i].
REQ-007 Port req_data, input, D*N bits: requester i write data in bits [D*i+D-1:D*i].
REQ-008 Port hold, input, 1 bit: high blocks new grants, for example during a debug freeze.
REQ-009 Port req_ready, output, N bits: one-hot or zero grant, combinational, for the current cycle.
REQ-010 Port A3, output, 5 bits: register file write address.
REQ-011 Port WD3, output, D bits: register file write data.
REQ-012 Port WE3, output, 1 bit: register file write enable.
REQ-013 Port pend_valid and pend_addr, outputs, 1 and 5 bits: the write in flight, for hazard checks by readers.
REQ-014 Port write_count, output, 16 bits: total writes issued to the register file.

Function
REQ-015 Output stage registers: valid_q, addr_q, data_q; assignments WE3=valid_q, A3=addr_q, WD3=data_q, pend_valid=valid_q, pend_addr=addr_q.
REQ-016 Transfer for requester i occurs on a rising edge where req_valid[i] and req_ready[i] are both 1.
REQ-017 req_ready has at most one bit set, and only for a bit with req_valid set.
REQ-018 req_ready is all zero when hold=1 or rst=1.
REQ-019 Grant selection is round-robin: search indices ptr, ptr+1, ... mod N; the first valid index wins.
REQ-020 After a grant to index g, ptr <= (g+1) mod N; with no grant, ptr holds its value.
REQ-021 On a transfer: valid_q<=1, addr_q<=granted req_addr, data_q<=granted req_data.
REQ-022 With no transfer: valid_q<=0, and addr_q/data_q hold their values.
REQ-023 Latency: a transfer at edge k gives WE3=1 with the granted A3/WD3 during cycle k+1, and the register file commits at edge k+1.
REQ-024 Throughput: one write per cycle; back-to-back grants are allowed with no bubble.
REQ-025 The output stage drains every cycle, so grants never depend on valid_q.
REQ-026 hold=1 does not cancel a write already in the output stage; that write completes on the next edge.
REQ-027 write_count increments by 1 on each edge where valid_q=1, and wraps from 0xFFFF to 0x0000.
REQ-028 Address 0 is treated as an ordinary register and is not filtered.
REQ-029 A requester must hold req_valid, req_addr and req_data stable until granted; the arbiter does not check this.
REQ-030 Two requesters targeting the same address in successive cycles are issued in grant order, and the last write wins.

Reset
REQ-031 While rst=1 at an edge: valid_q<=0, addr_q<=0, data_q<=0, ptr<=0, write_count<=0.
REQ-032 After reset, all outputs read 0: WE3, A3, WD3, pend_valid, pend_addr, write_count, req_ready.
REQ-033 Reset mid-operation discards any write in the output stage: WE3=0 in the cycle after the reset edge, with no register file commit.
REQ-034 The first grant after reset release follows ptr=0.

Verification (N=3, D=32)
REQ-035 Only req_valid[1]=1, addr 5, data 0xDEADBEEF -> req_ready=3'b010 in that cycle; next cycle WE3=1, A3=5, WD3=0xDEADBEEF; then write_count=1.
REQ-036 All three valid for 6 cycles from reset -> grant order 0,1,2,0,1,2; WE3 high for 6 consecutive cycles; write_count=6.
REQ-037 ptr=1, req_valid=3'b101 held -> grant 2, then grant 0.
REQ-038 hold=1 in the cycle after a grant, all valid -> req_ready=0; pending write still issues (WE3=1 one cycle), then WE3=0 while hold stays high.
REQ-039 rst=1 in the cycle after a transfer (valid_q=1) -> next cycle WE3=0, write_count=0, ptr=0; the next grant goes to the lowest valid index.
REQ-040 write_count=0xFFFF, one more write -> write_count=0x0000.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter funnelling N write requesters into a single register file write port
// through one output register stage (one write per cycle, one cycle of latency).
module rf_write_arbiter #(
   parameter int D = 32,
   parameter int N = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req_valid,
   input  logic [5*N-1:0]   req_addr,
   input  logic [D*N-1:0]   req_data,
   input  logic             hold,
   output logic [N-1:0]     req_ready,
   output logic [4:0]       A3,
   output logic [D-1:0]     WD3,
   output logic             WE3,
   output logic             pend_valid,
   output logic [4:0]       pend_addr,
   output logic [15:0]      write_count
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] r_ptr;
   logic          r_valid_q;
   logic [4:0]    r_addr_q;
   logic [D-1:0]  r_data_q;
   logic [15:0]   r_write_count;

   logic [PW:0]   w_sum  [N];
   logic [PW-1:0] w_cand [N];
   logic          w_found;
   logic [PW-1:0] w_gidx;
   logic          w_grant_en;

   // Candidate k is (ptr + k) mod N; ptr < N and k < N, so one conditional subtract suffices.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_cand
         assign w_sum[gi]  = {1'b0, r_ptr} + (PW+1)'(gi);
         assign w_cand[gi] = (w_sum[gi] >= (PW+1)'(N)) ? PW'(w_sum[gi] - (PW+1)'(N))
                                                       : w_sum[gi][PW-1:0];
      end
   endgenerate

   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      for (int k = 0; k < N; k++) begin
         if (!w_found && req_valid[w_cand[k]]) begin
            w_found = 1'b1;
            w_gidx  = w_cand[k];
         end
      end
   end

   assign w_grant_en = w_found & ~hold & ~rst;
   assign req_ready  = w_grant_en ? (N'(1) << w_gidx) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr         <= '0;
         r_valid_q     <= 1'b0;
         r_addr_q      <= '0;
         r_data_q      <= '0;
         r_write_count <= '0;
      end else begin
         if (w_grant_en) begin
            r_valid_q <= 1'b1;
            r_addr_q  <= req_addr[w_gidx*5 +: 5];
            r_data_q  <= req_data[w_gidx*D +: D];
            r_ptr     <= (w_gidx == PW'(N-1)) ? '0 : w_gidx + 1'b1;
         end else begin
            r_valid_q <= 1'b0;
         end
         // Counts writes as they leave the output stage; wraps naturally at 16 bits.
         if (r_valid_q)
            r_write_count <= r_write_count + 16'd1;
      end
   end

   assign WE3         = r_valid_q;
   assign A3          = r_addr_q;
   assign WD3         = r_data_q;
   assign pend_valid  = r_valid_q;
   assign pend_addr   = r_addr_q;
   assign write_count = r_write_count;

endmodule
